// File: rtl/noc_pkg.sv
// Shared NoC definitions: port codes, flit type codes and type-field geometry.
package noc_pkg;

  localparam logic [2:0] PORT_LOCAL = 3'b000;
  localparam logic [2:0] PORT_E     = 3'b001;
  localparam logic [2:0] PORT_W     = 3'b010;
  localparam logic [2:0] PORT_N     = 3'b011;
  localparam logic [2:0] PORT_S     = 3'b100;
  localparam logic [2:0] PORT_NONE  = 3'b111;

  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_HEAD   = 2'b01;
  localparam logic [1:0] FLIT_TAIL   = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;

  // The type field occupies the top FLIT_TYPE_W bits of every flit.
  localparam int FLIT_TYPE_W = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } route_state_t;

endpackage

// File: rtl/xy_route_calc.sv
// Combinational dimension-order route computation.
// Default is XY order; defining ROUTE_YX_EN resolves Y before X.
module xy_route_calc
  import noc_pkg::*;
#(
  parameter int N_ADD      = 2,
  parameter int N_REGISTER = 3
) (
  input  logic [N_ADD-1:0]      x_cur,
  input  logic [N_ADD-1:0]      y_cur,
  input  logic [N_ADD-1:0]      x_des,
  input  logic [N_ADD-1:0]      y_des,
  output logic [N_REGISTER-1:0] port
);

  // Unsigned coordinate compare selecting the output direction.
  always_comb begin
    port = N_REGISTER'(PORT_LOCAL);
`ifdef ROUTE_YX_EN
    if (y_des > y_cur)      port = N_REGISTER'(PORT_N);
    else if (y_des < y_cur) port = N_REGISTER'(PORT_S);
    else if (x_des > x_cur) port = N_REGISTER'(PORT_E);
    else if (x_des < x_cur) port = N_REGISTER'(PORT_W);
    else                    port = N_REGISTER'(PORT_LOCAL);
`else
    if (x_des > x_cur)      port = N_REGISTER'(PORT_E);
    else if (x_des < x_cur) port = N_REGISTER'(PORT_W);
    else if (y_des > y_cur) port = N_REGISTER'(PORT_N);
    else if (y_des < y_cur) port = N_REGISTER'(PORT_S);
    else                    port = N_REGISTER'(PORT_LOCAL);
`endif
  end

endmodule

// File: rtl/input_route_ctrl.sv
// Router input-port controller: wormhole route lock plus one-entry valid/ready output stage.
// Dimension order comes from xy_route_calc (macro ROUTE_YX_EN selects YX).
module input_route_ctrl
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int N_ADD      = 2,
  parameter int N_REGISTER = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_ADD-1:0]      X_cur,
  input  logic [N_ADD-1:0]      Y_cur,
  input  logic [DATA_WIDTH-1:0] Data_in,
  input  logic                  empty,
  output logic                  read,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_REGISTER-1:0] register,
  output logic                  route_err
);

  localparam int TYPE_LO = DATA_WIDTH - FLIT_TYPE_W;

  route_state_t            state_r, state_nxt_s;
  logic [N_ADD-1:0]        x_cur_r, y_cur_r;
  logic [N_REGISTER-1:0]   route_lat_r;
  logic [N_REGISTER-1:0]   route_calc_s, route_sel_s;
  logic [FLIT_TYPE_W-1:0]  flit_type_s;
  logic                    read_s, fwd_s, drop_s, lock_s;

  assign flit_type_s = Data_in[DATA_WIDTH-1:TYPE_LO];
  assign read_s      = !rst && !empty && (!out_valid || out_ready);
  assign read        = read_s;

  xy_route_calc #(
    .N_ADD      (N_ADD),
    .N_REGISTER (N_REGISTER)
  ) u_route (
    .x_cur (x_cur_r),
    .y_cur (y_cur_r),
    .x_des (Data_in[N_ADD-1:0]),
    .y_des (Data_in[2*N_ADD-1:N_ADD]),
    .port  (route_calc_s)
  );

  // Packet FSM: classify the popped flit as forward/drop and choose its route.
  always_comb begin
    state_nxt_s = state_r;
    fwd_s       = 1'b0;
    drop_s      = 1'b0;
    lock_s      = 1'b0;
    route_sel_s = route_lat_r;
    if (read_s) begin
      case (state_r)
        ST_IDLE: begin
          case (flit_type_s)
            FLIT_HEAD: begin
              fwd_s       = 1'b1;
              lock_s      = 1'b1;
              route_sel_s = route_calc_s;
              state_nxt_s = ST_PKT;
            end
            FLIT_SINGLE: begin
              fwd_s       = 1'b1;
              route_sel_s = route_calc_s;
            end
            default: drop_s = 1'b1;
          endcase
        end
        ST_PKT: begin
          case (flit_type_s)
            FLIT_BODY: fwd_s = 1'b1;
            FLIT_TAIL: begin
              fwd_s       = 1'b1;
              state_nxt_s = ST_IDLE;
            end
            default: drop_s = 1'b1;  // stray head/single keeps the lock
          endcase
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, coordinates and route latch; coordinates track the pins only under reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      route_lat_r <= N_REGISTER'(PORT_NONE);
      x_cur_r     <= X_cur;
      y_cur_r     <= Y_cur;
    end else begin
      state_r <= state_nxt_s;
      if (lock_s) route_lat_r <= route_calc_s;
    end
  end

  // Output stage: load on forward, clear when drained, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      Data_out  <= {DATA_WIDTH{1'b0}};
      register  <= N_REGISTER'(PORT_NONE);
      route_err <= 1'b0;
    end else begin
      route_err <= drop_s;
      if (fwd_s) begin
        out_valid <= 1'b1;
        Data_out  <= Data_in;
        register  <= route_sel_s;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        Data_out  <= {DATA_WIDTH{1'b0}};
        register  <= N_REGISTER'(PORT_NONE);
      end
    end
  end

endmodule

// File: tb/tb_input_route_ctrl.sv
// Directed scoreboard bench for input_route_ctrl (router at X=1, Y=1).
module tb_input_route_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] X_cur, Y_cur;
  logic [7:0] Data_in;
  logic       empty;
  logic       read;
  logic [7:0] Data_out;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] register;
  logic       route_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [10:0] sb_q[$];   // {data, port}
  logic        m_pkt;
  logic [2:0]  m_route;
  logic        m_err;

  input_route_ctrl #(.DATA_WIDTH(8), .N_ADD(2), .N_REGISTER(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .X_cur     (X_cur),
    .Y_cur     (Y_cur),
    .Data_in   (Data_in),
    .empty     (empty),
    .read      (read),
    .Data_out  (Data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .register  (register),
    .route_err (route_err)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] ref_route(input logic [7:0] f);
    logic [1:0] xd, yd;
    xd = f[1:0];
    yd = f[3:2];
`ifdef ROUTE_YX_EN
    if (yd != 2'd1) return (yd > 2'd1) ? 3'b011 : 3'b100;
    if (xd != 2'd1) return (xd > 2'd1) ? 3'b001 : 3'b010;
`else
    if (xd != 2'd1) return (xd > 2'd1) ? 3'b001 : 3'b010;
    if (yd != 2'd1) return (yd > 2'd1) ? 3'b011 : 3'b100;
`endif
    return 3'b000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive, check read and output stage, update model, check error pulse.
  task automatic cycle(input logic [7:0] d, input logic e, input logic rdy);
    logic       exp_read;
    logic [1:0] ft;
    Data_in   = d;
    empty     = e;
    out_ready = rdy;
    #1;
    exp_read = !e && ((sb_q.size() == 0) || rdy);
    chk("read", {31'd0, read}, {31'd0, exp_read});
    if (sb_q.size() != 0) begin
      chk("out_valid", {31'd0, out_valid}, 32'd1);
      chk("data", {24'd0, Data_out}, {24'd0, sb_q[0][10:3]});
      chk("register", {29'd0, register}, {29'd0, sb_q[0][2:0]});
      if (rdy) void'(sb_q.pop_front());
    end else begin
      chk("out_valid", {31'd0, out_valid}, 32'd0);
      chk("register_idle", {29'd0, register}, 32'd7);
    end
    m_err = 1'b0;
    if (exp_read) begin
      ft = d[7:6];
      if (!m_pkt) begin
        if (ft == 2'b01) begin
          m_route = ref_route(d);
          m_pkt   = 1'b1;
          sb_q.push_back({d, m_route});
        end else if (ft == 2'b11) sb_q.push_back({d, ref_route(d)});
        else m_err = 1'b1;
      end else begin
        if (ft == 2'b00) sb_q.push_back({d, m_route});
        else if (ft == 2'b10) begin
          sb_q.push_back({d, m_route});
          m_pkt = 1'b0;
        end else m_err = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("route_err", {31'd0, route_err}, {31'd0, m_err});
  endtask

  initial begin
    rst = 1'b1; X_cur = 2'd1; Y_cur = 2'd1;
    Data_in = 8'h00; empty = 1'b1; out_ready = 1'b1;
    m_pkt = 1'b0; m_route = 3'b111; m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {24'd0, Data_out}, 32'd0);
    chk("rst_register", {29'd0, register}, 32'd7);
    chk("rst_err", {31'd0, route_err}, 32'd0);
    chk("rst_read", {31'd0, read}, 32'd0);
    rst = 1'b0;

    // single flit to E
    cycle(8'hC6, 1'b0, 1'b1);
    chk("single_reg_E", {29'd0, register}, 32'd1);
    cycle(8'h00, 1'b1, 1'b1);
    cycle(8'h00, 1'b1, 1'b1);

    // back-to-back packet to W
    cycle(8'h44, 1'b0, 1'b1);
    cycle(8'h0F, 1'b0, 1'b1);
    cycle(8'h80, 1'b0, 1'b1);
    chk("tail_reg_W", {29'd0, register}, 32'd2);
    cycle(8'h00, 1'b1, 1'b1);
    cycle(8'h00, 1'b1, 1'b1);

    // stall after the head
    cycle(8'h44, 1'b0, 1'b1);
    cycle(8'h0F, 1'b0, 1'b0);
    cycle(8'h0F, 1'b0, 1'b0);
    cycle(8'h0F, 1'b0, 1'b0);
    chk("stall_hold", {24'd0, Data_out}, 32'h44);
    cycle(8'h0F, 1'b0, 1'b1);
    cycle(8'h80, 1'b0, 1'b1);
    cycle(8'h00, 1'b1, 1'b1);
    cycle(8'h00, 1'b1, 1'b1);

    // malformed flits: body in IDLE, second head mid-packet
    cycle(8'h05, 1'b0, 1'b1);
    cycle(8'h00, 1'b1, 1'b1);
    cycle(8'h44, 1'b0, 1'b1);
    cycle(8'h55, 1'b0, 1'b1);
    cycle(8'h0F, 1'b0, 1'b1);
    chk("lock_kept_W", {29'd0, register}, 32'd2);
    cycle(8'h80, 1'b0, 1'b1);
    cycle(8'h00, 1'b1, 1'b1);

    // local destination, then the XY/YX discriminating head
    cycle(8'h55, 1'b0, 1'b1);
    chk("local_reg", {29'd0, register}, 32'd0);
    cycle(8'h80, 1'b0, 1'b1);
    cycle(8'h78, 1'b0, 1'b1);
`ifdef ROUTE_YX_EN
    chk("dim_order", {29'd0, register}, 32'd3);
`else
    chk("dim_order", {29'd0, register}, 32'd2);
`endif
    cycle(8'h80, 1'b0, 1'b1);
    cycle(8'h00, 1'b1, 1'b1);
    cycle(8'h00, 1'b1, 1'b1);

    // reset mid-packet
    cycle(8'h44, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_register", {29'd0, register}, 32'd7);
    chk("midrst_read", {31'd0, read}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    m_pkt = 1'b0;
    cycle(8'h0F, 1'b0, 1'b1);
    cycle(8'h00, 1'b1, 1'b1);
    cycle(8'h00, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/input_route_ctrl.md
Name: input_route_ctrl

Overview:
- Parametrised successor of the router input controller.
- Pulls flits from one input-port FIFO and computes the XY route from the head flit.
- Locks that route for the whole wormhole packet until the tail flit leaves.
- Presents each flit with its output-port code to the switch through a one-entry valid/ready output stage. One instance per router input port.

Parameters:
- DATA_WIDTH, 8, flit width; must be >= 2*N_ADD+2.
- N_ADD, 2, width of each X/Y coordinate.
- N_REGISTER, 3, width of the output-port code.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- X_cur  in  N_ADD  router X coordinate; sampled while rst is high.
- Y_cur  in  N_ADD  router Y coordinate; sampled while rst is high.
- Data_in  in  DATA_WIDTH  FIFO head flit; valid when empty=0.
- empty  in  1  FIFO empty.
- read  out  1  FIFO pop strobe; the flit is consumed on the same edge.
- Data_out  out  DATA_WIDTH  registered flit to the switch.
- out_valid  out  1  Data_out/register are valid.
- out_ready  in  1  switch accepts the flit this cycle.
- register  out  N_REGISTER  output-port code.
- route_err  out  1  one-cycle pulse on a dropped, malformed flit.

Behaviour:
- Flit type field is Data_in[DATA_WIDTH-1:DATA_WIDTH-2]:
  - 01 = head
  - 00 = body
  - 10 = tail
  - 11 = single (head+tail)
- Head/single flits carry x_des = [N_ADD-1:0] and y_des = [2*N_ADD-1:N_ADD].
- Port codes:
  - 000 local
  - 001 E
  - 010 W
  - 011 N
  - 100 S
  - 111 none
- XY rule (unsigned compare):
  - x_des > x_cur → E; x_des < x_cur → W.
  - Otherwise y_des > y_cur → N; y_des < y_cur → S; else local.
- Reset (async): state=IDLE, out_valid=0, Data_out=0, register=111, route_err=0, route latch=111, x_cur/y_cur ← X_cur/Y_cur.
- read = !rst && !empty && (!out_valid || out_ready). Combinational; never asserted when the output stage is full and stalled.
- Latency: the flit popped at edge N appears on Data_out with out_valid=1 after edge N.
- Output stage:
  - Holds Data_out/register stable while out_valid && !out_ready.
  - Accept and refill in the same cycle is allowed (full throughput, 1 flit/cycle).
  - out_valid drops to 0 when accepted with no new pop.
- FSM, two states:
  - IDLE: head pops → compute route, latch it, forward the flit, go to PKT. Single pops → compute route, forward, stay in IDLE. Body/tail pops → drop (out_valid stays 0 unless already full), route_err=1 for one cycle.
  - PKT: body pops → forward with the latched route. Tail pops → forward with the latched route, go to IDLE. Head/single pops → drop, route_err=1, stay in PKT (packet lock is kept).
- register tracks the flit in the output stage. When out_valid=0, register=111 and Data_out=0.
- Reset mid-packet: immediate return to IDLE; the partially sent packet is abandoned, with no error pulse.
- Coordinates change only while rst=1.

Optional Feature:
- Macro ROUTE_YX_EN.
- Defined: dimension order is swapped to YX. Y is resolved first (N/S), then X (E/W), then local.
- Undefined: XY as above.
- Handshake and FSM are identical in both cases.

Decomposition:
- Shared package noc_pkg holds:
  - port codes PORT_LOCAL/E/W/N/S/NONE
  - flit type codes FLIT_HEAD/BODY/TAIL/SINGLE
  - localparams for the type-field position.
- Natural sub-module: xy_route_calc. Purely combinational: inputs cur/des coordinates, output port code; contains the ROUTE_YX_EN switch.
- FSM and output stage stay in input_route_ctrl.

Test Plan:
- Reset with X_cur=1, Y_cur=1; single flit 8'hC6 (x=2, y=1), out_ready=1 → read=1 for one cycle; next cycle Data_out=C6, register=001, out_valid=1.
- Head 8'h44 (x=0, y=1), body 8'h0F, tail 8'h80 back-to-back, out_ready=1 → three consecutive valid cycles, all register=010, FSM back to IDLE after the tail.
- Same packet with out_ready=0 for 3 cycles after the head → read=0 while stalled, Data_out=44 held, no flit loss, order preserved on release.
- Body 8'h05 arriving in IDLE → read=1, route_err pulses one cycle, out_valid stays 0; a second head mid-packet → dropped, route_err=1, latched route unchanged.
- Head 8'h55 (x=1, y=1) → register=000 local; with ROUTE_YX_EN, head 8'h78 (x=0, y=2) → register=011 N (XY build gives 010 W).
- rst asserted mid-packet after the head → out_valid=0 and register=111 immediately; a following body flit after reset release is dropped with route_err=1.
